// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - program loader state and target encodings
package loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

endpackage

// File: rtl/loader_addr_counter.sv
// rtl/loader_addr_counter.sv - per-target write address counter with full flag
module loader_addr_counter #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [AW:0] count,
  output logic        full
);

  localparam logic [AW:0] FULL_VAL = (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign full = (count == FULL_VAL);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams program/data into processor memories, then sequences run
// Optional LOADER_CHECKSUM_EN adds a running checksum of written words.
module program_loader
  import loader_pkg::*;
#(
  parameter  int WORD_W     = 32,
  parameter  int IMEM_DEPTH = 256,
  parameter  int DMEM_DEPTH = 256,
  localparam int IA_W       = $clog2(IMEM_DEPTH),
  localparam int DA_W       = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_target,
  input  logic              in_last,
  input  logic              restart,
  input  logic              run_done,
  output logic              imem_we,
  output logic [IA_W-1:0]   imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [DA_W-1:0]   dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic              start_signal,
  output logic [IA_W:0]     imem_count,
  output logic [DA_W:0]     dmem_count,
  output logic              load_err,
  output logic [1:0]        state
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  loader_state_e state_q, state_d;
  logic imem_inc, dmem_inc, clr_counts;
  logic imem_full, dmem_full, tgt_full;

  loader_addr_counter #(.DEPTH(IMEM_DEPTH)) u_imem_cnt (
    .clk(clk), .reset(reset), .inc(imem_inc), .clr(clr_counts),
    .count(imem_count), .full(imem_full)
  );

  loader_addr_counter #(.DEPTH(DMEM_DEPTH)) u_dmem_cnt (
    .clk(clk), .reset(reset), .inc(dmem_inc), .clr(clr_counts),
    .count(dmem_count), .full(dmem_full)
  );

  assign tgt_full = (in_target == TGT_DMEM) ? dmem_full : imem_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    start_signal = 1'b0;
    load_err     = 1'b0;
    imem_inc     = 1'b0;
    dmem_inc     = 1'b0;
    clr_counts   = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (tgt_full) begin
            state_d = ERR;
          end else begin
            imem_inc = (in_target == TGT_IMEM);
            dmem_inc = (in_target == TGT_DMEM);
            // A program with no instruction words cannot run
            if (in_last) begin
              state_d = (in_target == TGT_DMEM && imem_count == '0) ? ERR : RUN;
            end
          end
        end
      end
      RUN: begin
        start_signal = 1'b1;
        if (run_done) state_d = DONE;
      end
      DONE: begin
        if (restart) begin
          state_d    = LOAD;
          clr_counts = 1'b1;
        end
      end
      ERR: begin
        load_err = 1'b1;
        if (restart) begin
          state_d    = LOAD;
          clr_counts = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Write ports are registered so the strobe lines up with the count increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= imem_inc;
      dmem_we <= dmem_inc;
      if (imem_inc) begin
        imem_addr  <= imem_count[IA_W-1:0];
        imem_wdata <= in_data;
      end
      if (dmem_inc) begin
        dmem_addr  <= dmem_count[DA_W-1:0];
        dmem_wdata <= in_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (clr_counts) begin
      checksum <= '0;
    end else if (imem_inc || dmem_inc) begin
      checksum <= checksum + in_data;
    end
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_target;
  logic        in_last;
  logic        restart;
  logic        run_done;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [1:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        start_signal;
  logic [2:0]  imem_count;
  logic [2:0]  dmem_count;
  logic        load_err;
  logic [1:0]  state;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int vecs = 0;
  int errs = 0;

  program_loader #(.WORD_W(32), .IMEM_DEPTH(4), .DMEM_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_target(in_target), .in_last(in_last),
    .restart(restart), .run_done(run_done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .start_signal(start_signal), .imem_count(imem_count), .dmem_count(dmem_count),
    .load_err(load_err), .state(state)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] d, input logic t, input logic l);
    in_valid = 1'b1; in_data = d; in_target = t; in_last = l;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_target = 1'b0; in_last = 1'b0;
    restart = 1'b0; run_done = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0;
    step(); step();
    vecs++; if (state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vecs++; if ({imem_we, dmem_we, start_signal, load_err} !== 4'b0) begin errs++; $display("FAIL reset_flags got %4b want 0000", {imem_we, dmem_we, start_signal, load_err}); end
    vecs++; if ({imem_count, dmem_count, imem_addr, dmem_addr} !== 10'd0) begin errs++; $display("FAIL reset_counts got %0h want 0", {imem_count, dmem_count, imem_addr, dmem_addr}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    logic [31:0] d [3];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    beat(d[0], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (imem_we !== 1'b1 || dmem_we !== 1'b0) begin errs++; $display("FAIL basic_we%0d got i=%0b d=%0b want i=1 d=0", i, imem_we, dmem_we); end
      vecs++; if (imem_addr !== 2'(i)) begin errs++; $display("FAIL basic_addr%0d got %0d want %0d", i, imem_addr, i); end
      vecs++; if (imem_wdata !== d[i]) begin errs++; $display("FAIL basic_data%0d got %0h want %0h", i, imem_wdata, d[i]); end
      vecs++; if (imem_count !== 3'(i + 1)) begin errs++; $display("FAIL basic_count%0d got %0d want %0d", i, imem_count, i + 1); end
      if (i < 2) beat(d[i+1], 1'b0, i == 1);
      else idle();
    end
    vecs++; if (state !== 2'd1 || start_signal !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL basic_run got st=%0d start=%0b rdy=%0b want 1/1/0", state, start_signal, in_ready); end
    step();
    vecs++; if (imem_we !== 1'b0 || imem_count !== 3'd3) begin errs++; $display("FAIL basic_frozen got we=%0b cnt=%0d want 0/3", imem_we, imem_count); end
  endtask

  task automatic test_run_done();
    restart = 1'b1;
    step();
    vecs++; if (state !== 2'd1) begin errs++; $display("FAIL restart_in_run got %0d want 1", state); end
    restart = 1'b0; run_done = 1'b1;
    step();
    vecs++; if (state !== 2'd2 || start_signal !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL done got st=%0d start=%0b rdy=%0b want 2/0/0", state, start_signal, in_ready); end
    step();
    vecs++; if (state !== 2'd2) begin errs++; $display("FAIL done_ignores_run_done got %0d want 2", state); end
    run_done = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    vecs++; if (state !== 2'd0 || imem_count !== 3'd0 || dmem_count !== 3'd0) begin errs++; $display("FAIL done_restart got st=%0d ic=%0d dc=%0d want 0/0/0", state, imem_count, dmem_count); end
  endtask

  task automatic test_interleave();
    beat(32'hA0, 1'b0, 1'b0); step();
    vecs++; if (imem_we !== 1'b1 || dmem_we !== 1'b0 || imem_addr !== 2'd0 || imem_wdata !== 32'hA0) begin errs++; $display("FAIL il_i0 got we=%0b/%0b a=%0d d=%0h want 1/0 0 a0", imem_we, dmem_we, imem_addr, imem_wdata); end
    beat(32'hB0, 1'b1, 1'b0); step();
    vecs++; if (imem_we !== 1'b0 || dmem_we !== 1'b1 || dmem_addr !== 2'd0 || dmem_wdata !== 32'hB0) begin errs++; $display("FAIL il_d0 got we=%0b/%0b a=%0d d=%0h want 0/1 0 b0", imem_we, dmem_we, dmem_addr, dmem_wdata); end
    beat(32'hA1, 1'b0, 1'b0); step();
    vecs++; if (imem_we !== 1'b1 || dmem_we !== 1'b0 || imem_addr !== 2'd1 || imem_wdata !== 32'hA1) begin errs++; $display("FAIL il_i1 got we=%0b/%0b a=%0d d=%0h want 1/0 1 a1", imem_we, dmem_we, imem_addr, imem_wdata); end
    beat(32'hB1, 1'b1, 1'b1); step();
    idle();
    vecs++; if (imem_we !== 1'b0 || dmem_we !== 1'b1 || dmem_addr !== 2'd1 || dmem_wdata !== 32'hB1) begin errs++; $display("FAIL il_d1 got we=%0b/%0b a=%0d d=%0h want 0/1 1 b1", imem_we, dmem_we, dmem_addr, dmem_wdata); end
    vecs++; if (dmem_count !== 3'd2 || imem_count !== 3'd2 || state !== 2'd1) begin errs++; $display("FAIL il_counts got dc=%0d ic=%0d st=%0d want 2/2/1", dmem_count, imem_count, state); end
    run_done = 1'b1; step();
    run_done = 1'b0; restart = 1'b1; step();
    restart = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      beat(32'h100 + 32'(i), 1'b0, 1'b0);
      step();
      if (i < 4) begin
        vecs++; if (imem_we !== 1'b1 || imem_addr !== 2'(i)) begin errs++; $display("FAIL ovf_write%0d got we=%0b a=%0d want 1/%0d", i, imem_we, imem_addr, i); end
      end
    end
    idle();
    vecs++; if (imem_we !== 1'b0 || state !== 2'd3 || load_err !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL ovf_err got we=%0b st=%0d err=%0b rdy=%0b want 0/3/1/0", imem_we, state, load_err, in_ready); end
    vecs++; if (imem_count !== 3'd4) begin errs++; $display("FAIL ovf_count got %0d want 4", imem_count); end
    restart = 1'b1; step();
    restart = 1'b0;
    vecs++; if (state !== 2'd0 || load_err !== 1'b0 || imem_count !== 3'd0) begin errs++; $display("FAIL ovf_restart got st=%0d err=%0b ic=%0d want 0/0/0", state, load_err, imem_count); end
  endtask

  task automatic test_empty_program();
    beat(32'hD0, 1'b1, 1'b1); step();
    idle();
    vecs++; if (dmem_we !== 1'b1 || dmem_addr !== 2'd0 || dmem_wdata !== 32'hD0) begin errs++; $display("FAIL empty_write got we=%0b a=%0d d=%0h want 1/0/d0", dmem_we, dmem_addr, dmem_wdata); end
    vecs++; if (state !== 2'd3 || load_err !== 1'b1 || start_signal !== 1'b0) begin errs++; $display("FAIL empty_err got st=%0d err=%0b start=%0b want 3/1/0", state, load_err, start_signal); end
    step();
    vecs++; if (dmem_we !== 1'b0) begin errs++; $display("FAIL empty_nowrite got %0b want 0", dmem_we); end
    restart = 1'b1; step();
    restart = 1'b0;
  endtask

  task automatic test_restart_ignored_in_load();
    beat(32'h5, 1'b0, 1'b0); step();
    idle(); restart = 1'b1; step();
    restart = 1'b0;
    vecs++; if (imem_count !== 3'd1 || state !== 2'd0) begin errs++; $display("FAIL load_restart got ic=%0d st=%0d want 1/0", imem_count, state); end
    reset = 1'b0; step(); reset = 1'b1;
  endtask

  task automatic test_reset_midload();
    beat(32'h71, 1'b0, 1'b0); step();
    beat(32'h72, 1'b1, 1'b0); step();
    beat(32'h73, 1'b0, 1'b0); reset = 1'b0; step();
    vecs++; if (imem_count !== 3'd0 || dmem_count !== 3'd0 || imem_we !== 1'b0 || dmem_we !== 1'b0 || state !== 2'd0) begin errs++; $display("FAIL midload_reset got ic=%0d dc=%0d we=%0b/%0b st=%0d want 0", imem_count, dmem_count, imem_we, dmem_we, state); end
    idle(); reset = 1'b1; step();
    vecs++; if (imem_we !== 1'b0 || dmem_we !== 1'b0 || imem_count !== 3'd0) begin errs++; $display("FAIL midload_quiet got we=%0b/%0b ic=%0d want 0/0/0", imem_we, dmem_we, imem_count); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    beat(32'hFFFF_FFFF, 1'b0, 1'b0); step();
    beat(32'h2, 1'b0, 1'b1); step();
    idle();
    vecs++; if (checksum !== 32'h1) begin errs++; $display("FAIL checksum got %0h want 1", checksum); end
    run_done = 1'b1; step();
    run_done = 1'b0; restart = 1'b1; step();
    restart = 1'b0;
    vecs++; if (checksum !== 32'h0) begin errs++; $display("FAIL checksum_clear got %0h want 0", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_run_done();
    test_interleave();
    test_overflow();
    test_empty_program();
    test_restart_ignored_in_load();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
